// File: rtl/sqrt2_host.sv
// Host sequencer for a shared-bus binary16 square-root core: accepts one operand,
// drives it onto the bidirectional bus, waits for the core (with timeout) and returns the result.
module sqrt2_host #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [2:0]  out_flags,
    output logic        out_timeout,
    output logic [15:0] op_count,
    inout  wire  [15:0] io_data,
    output logic        sq_enable,
    input  logic        sq_result,
    input  logic        sq_is_nan,
    input  logic        sq_is_pinf,
    input  logic        sq_is_ninf
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RELEASE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] operand_reg;
    logic [15:0] wait_cnt_reg;
    logic [15:0] out_data_reg;
    logic [2:0]  out_flags_reg;
    logic        out_timeout_reg;
    logic [15:0] op_count_reg;
    logic        bus_drive;
    logic        bus_en;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        sq_enable  = 1'b0;
        bus_drive  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                bus_drive  = 1'b1;
                state_next = ST_START;
            end
            ST_START: begin
                bus_drive  = 1'b1;
                sq_enable  = 1'b1;
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                sq_enable  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                sq_enable = 1'b1;
                if (sq_result || (wait_cnt_reg == WAIT_LAST)) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            operand_reg     <= '0;
            wait_cnt_reg    <= '0;
            out_data_reg    <= '0;
            out_flags_reg   <= '0;
            out_timeout_reg <= 1'b0;
            op_count_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && in_valid) operand_reg <= in_data;
            wait_cnt_reg <= (state_reg == ST_WAIT) ? wait_cnt_reg + 16'd1 : 16'd0;
            // A core result on the terminal wait cycle wins over the timeout abort.
            if (state_reg == ST_WAIT) begin
                if (sq_result) begin
                    out_data_reg    <= io_data;
                    out_flags_reg   <= {sq_is_nan, sq_is_pinf, sq_is_ninf};
                    out_timeout_reg <= 1'b0;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    out_data_reg    <= 16'hFE00;
                    out_flags_reg   <= 3'b100;
                    out_timeout_reg <= 1'b1;
                end
            end
            if (state_reg == ST_DONE && out_ready) op_count_reg <= op_count_reg + 16'd1;
        end
    end

    // Bus released while reset is asserted, even before the state register settles.
    assign bus_en = bus_drive && !reset;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bus
            assign io_data[gi] = bus_en ? operand_reg[gi] : 1'bz;
        end
    endgenerate

    assign out_data    = out_data_reg;
    assign out_flags   = out_flags_reg;
    assign out_timeout = out_timeout_reg;
    assign op_count    = op_count_reg;

endmodule

// File: tb/tb_sqrt2_host.sv
// Randomized self-checking bench for sqrt2_host with a behavioural sqrt core on the shared bus.
module tb_sqrt2_host;
    localparam int T = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, out_valid, out_timeout, sq_enable;
    logic [15:0] out_data, op_count;
    logic [2:0]  out_flags;
    wire  [15:0] io_bus;
    logic        sq_result, sq_is_nan, sq_is_pinf, sq_is_ninf;

    logic        core_busy = 1'b0;
    logic        en_prev = 1'b0;
    int          core_cnt = 0;
    int          core_lat = 0;
    logic [15:0] core_res = '0;
    logic [2:0]  core_flags = '0;
    logic [15:0] bus_op = 16'h1234;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] model_count = '0;

    sqrt2_host #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .out_timeout(out_timeout), .op_count(op_count),
        .io_data(io_bus), .sq_enable(sq_enable), .sq_result(sq_result),
        .sq_is_nan(sq_is_nan), .sq_is_pinf(sq_is_pinf), .sq_is_ninf(sq_is_ninf)
    );

    always #5 clk = ~clk;

    function automatic real pow2(input int n);
        real p;
        p = 1.0;
        for (int i = 0; i < n; i++) p = p * 2.0;
        for (int i = 0; i > n; i--) p = p / 2.0;
        return p;
    endfunction

    // Reference binary16 square root: {result, nan, pinf, ninf}.
    function automatic logic [18:0] fp16_sqrt(input logic [15:0] a);
        int  e, m, ex;
        real x, s;
        e = int'(a[14:10]);
        m = int'(a[9:0]);
        if (e == 31 && m != 0) return {16'hFE00, 3'b100};
        if (e == 0 && m == 0) return {a, 3'b000};
        if (a[15]) return (e == 31) ? {16'hFE00, 3'b001} : {16'hFE00, 3'b100};
        if (e == 31) return {16'h7C00, 3'b010};
        x = (e == 0) ? real'(m) * pow2(-24) : real'(m + 1024) * pow2(e - 25);
        s = $sqrt(x);
        ex = 0;
        while (s >= 2.0) begin s = s / 2.0; ex++; end
        while (s < 1.0) begin s = s * 2.0; ex--; end
        m = $rtoi((s - 1.0) * 1024.0 + 0.5);
        if (m == 1024) begin m = 0; ex++; end
        return {1'b0, 5'(ex + 15), 10'(m), 3'b000};
    endfunction

    // Core: captures the bus on the edge that ends its first enabled cycle,
    // then answers after core_lat WAIT cycles and drives the bus while answering.
    always @(posedge clk) begin
        if (reset) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
        end else if (sq_enable && !en_prev) begin
            core_busy <= 1'b1;
            core_cnt  <= core_lat + 1;
            {core_res, core_flags} <= fp16_sqrt(io_bus);
        end else if (!sq_enable) begin
            core_busy <= 1'b0;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
        end
        en_prev <= reset ? 1'b0 : sq_enable;
    end

    assign sq_result = core_busy && sq_enable && (core_cnt == 0);
    assign {sq_is_nan, sq_is_pinf, sq_is_ninf} = core_flags;
    assign io_bus = sq_result ? core_res : 16'bz;

    function automatic logic host_drive();
        return !sq_result && (io_bus === bus_op);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input logic [15:0] op, input int lat, input int hold);
        logic [18:0] r;
        logic [15:0] exp_d;
        logic [2:0]  exp_f;
        logic        exp_to;
        int          exp_lat;
        int          k;
        r       = fp16_sqrt(op);
        exp_d   = r[18:3];
        exp_f   = r[2:0];
        exp_to  = 1'b0;
        exp_lat = 4 + lat;
        if (lat >= T) begin
            exp_d   = 16'hFE00;
            exp_f   = 3'b100;
            exp_to  = 1'b1;
            exp_lat = 3 + T;
        end
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        core_lat  = lat;
        bus_op    = op;
        in_valid  = 1'b1;
        in_data   = op;
        out_ready = 1'b0;
        @(negedge clk);
        k = 0;
        while (!out_valid && k < exp_lat + 4) begin
            check_eq("bus_drive", 32'(host_drive()), 32'(k < 2));
            check_eq("sq_enable", 32'(sq_enable), 32'(k >= 1));
            check_eq("in_ready_busy", 32'(in_ready), 32'd0);
            in_valid  = 1'($urandom);
            in_data   = 16'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("latency", 32'(k), 32'(exp_lat));
        for (int h = 0; h <= hold; h++) begin
            check_eq("out_valid", 32'(out_valid), 32'd1);
            check_eq("out_data", 32'(out_data), 32'(exp_d));
            check_eq("out_flags", 32'(out_flags), 32'(exp_f));
            check_eq("out_timeout", 32'(out_timeout), 32'(exp_to));
            check_eq("in_ready_done", 32'(in_ready), 32'd0);
            check_eq("sq_enable_done", 32'(sq_enable), 32'd0);
            check_eq("bus_drive_done", 32'(host_drive()), 32'd0);
            if (h == hold) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        model_count++;
        check_eq("out_valid_after", 32'(out_valid), 32'd0);
        check_eq("in_ready_after", 32'(in_ready), 32'd1);
        check_eq("op_count", 32'(op_count), 32'(model_count));
        check_eq("data_retained", 32'(out_data), 32'(exp_d));
        check_eq("flags_retained", 32'(out_flags), 32'(exp_f));
        check_eq("bus_drive_idle", 32'(host_drive()), 32'd0);
        $display("txn op=%h lat=%0d hold=%0d -> data=%h flags=%b timeout=%b cycles=%0d count=%0d",
                 op, lat, hold, out_data, out_flags, out_timeout, k, op_count);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_sq_enable"}, 32'(sq_enable), 32'd0);
        check_eq({tag, "_op_count"}, 32'(op_count), 32'd0);
        check_eq({tag, "_out_data"}, 32'(out_data), 32'd0);
        check_eq({tag, "_out_flags"}, 32'(out_flags), 32'd0);
        check_eq({tag, "_out_timeout"}, 32'(out_timeout), 32'd0);
        check_eq({tag, "_bus_drive"}, 32'(host_drive()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] op;
        int          k;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_sq_enable", 32'(sq_enable), 32'd0);
        check_eq("rst_bus_drive", 32'(host_drive()), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("por");

        run_txn(16'h4800, 0, 0);
        check_eq("sqrt8_const", 32'(out_data), 32'h41A8);
        run_txn(16'hBC00, 2, 0);
        check_eq("neg_const", 32'({out_data, out_flags}), 32'({16'hFE00, 3'b100}));
        run_txn(16'h7C00, 1, 0);
        check_eq("pinf_const", 32'({out_data, out_flags}), 32'({16'h7C00, 3'b010}));
        run_txn(16'hFC00, 0, 0);
        run_txn(16'h3C00, 1000, 0);
        check_eq("timeout_const", 32'({out_data, out_timeout}), 32'({16'hFE00, 1'b1}));
        run_txn(16'h4400, T - 1, 0);
        run_txn(16'h4400, T - 2, 0);
        run_txn(16'h4400, T, 1);
        run_txn(16'h4A00, 3, 10);

        for (int i = 0; i < 20; i++) begin
            do op = 16'($urandom); while (op == 16'h0000 || op == 16'hFFFF);
            run_txn(op, $urandom_range(0, T + 2), $urandom_range(0, 3));
        end

        // Reset pulsed while the host is waiting on the core.
        @(negedge clk);
        core_lat = 1000;
        bus_op   = 16'h4200;
        in_valid = 1'b1;
        in_data  = 16'h4200;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("mid_wait_sq_enable", 32'(sq_enable), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_count = '0;
        check_reset_state("wait_rst");
        run_txn(16'h3C00, 0, 0);
        check_eq("one_const", 32'(out_data), 32'h3C00);

        // Reset on the same edge as an output and an input handshake.
        core_lat = 0;
        bus_op   = 16'h4400;
        in_valid = 1'b1;
        in_data  = 16'h4400;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 10) begin @(negedge clk); k++; end
        check_eq("pre_rst_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_count = '0;
        check_reset_state("hs_rst");
        run_txn(16'h4800, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sqrt2_host.md
SQRT2_HOST -- requirements
Module: sqrt2_host

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, is the maximum cycles spent in WAIT before abort; legal range 2..65535.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset, sampled on rising CLK edge.
REQ-004 IN_VALID  in  1  upstream operand valid.
REQ-005 IN_READY  out  1  host can accept an operand.
REQ-006 IN_DATA  in  16  binary16 operand.
REQ-007 OUT_VALID  out  1  result valid.
REQ-008 OUT_READY  in  1  downstream accepts result.
REQ-009 OUT_DATA  out  16  binary16 result.
REQ-010 OUT_FLAGS  out  3  {NAN, PINF, NINF} captured with OUT_DATA.
REQ-011 OUT_TIMEOUT  out  1  result produced by timeout abort.
REQ-012 OP_COUNT  out  16  completed transactions, wraps modulo 2^16.
REQ-013 IO_DATA  inout  16  shared data bus to the sqrt2 core.
REQ-014 SQ_ENABLE  out  1  drives the core ENABLE input.
REQ-015 SQ_RESULT, SQ_IS_NAN, SQ_IS_PINF, SQ_IS_NINF  in  1 each  core status inputs.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, START, RELEASE, WAIT, DONE, all registered.
REQ-017 IN_READY SHALL be 1 only in IDLE; on the edge where IN_VALID and IN_READY are both 1, IN_DATA is latched and the FSM moves to LOAD.
REQ-018 LOAD (1 cycle): IO_DATA driven with the latched operand, SQ_ENABLE=0; next state START.
REQ-019 START (1 cycle): IO_DATA still driven, SQ_ENABLE=1; next state RELEASE.
REQ-020 RELEASE (1 cycle turnaround): IO_DATA high-Z, SQ_ENABLE=1, SQ_RESULT ignored; next state WAIT.
REQ-021 WAIT: IO_DATA high-Z, SQ_ENABLE=1; the wait counter increments each cycle from 0.
REQ-022 In WAIT with SQ_RESULT=1, the next edge SHALL capture IO_DATA into OUT_DATA and {SQ_IS_NAN,SQ_IS_PINF,SQ_IS_NINF} into OUT_FLAGS, clear OUT_TIMEOUT, and enter DONE.
REQ-023 In WAIT, if the counter reaches TIMEOUT_CYCLES-1 with SQ_RESULT=0, the next edge SHALL load OUT_DATA=16'hFE00, OUT_FLAGS=3'b100, OUT_TIMEOUT=1, and enter DONE.
REQ-024 SQ_RESULT=1 on the terminal timeout cycle SHALL take priority: normal capture, OUT_TIMEOUT=0.
REQ-025 DONE: OUT_VALID=1, SQ_ENABLE=0, IO_DATA high-Z; OUT_DATA, OUT_FLAGS, OUT_TIMEOUT held stable until handshake.
REQ-026 On the edge with OUT_VALID and OUT_READY both 1, the FSM SHALL return to IDLE and OP_COUNT increments (timeouts included); 16'hFFFF wraps to 0.
REQ-027 IO_DATA SHALL be driven only in LOAD and START; high-Z in every other state and during reset.
REQ-028 Minimum latency: accept edge to OUT_VALID = 4 cycles plus core cycles in WAIT (result seen on first WAIT cycle gives OUT_VALID 4 cycles after accept).
REQ-029 IN_VALID in any state other than IDLE SHALL have no effect; no operand buffering beyond one.
REQ-030 OUT_DATA, OUT_FLAGS, OUT_TIMEOUT SHALL retain their last values after returning to IDLE.

Reset
REQ-031 RESET=1 on an edge SHALL force IDLE from any state, including mid-WAIT.
REQ-032 Reset values: IN_READY=1 (after reset deasserts, combinational from IDLE), OUT_VALID=0, OUT_DATA=0, OUT_FLAGS=0, OUT_TIMEOUT=0, OP_COUNT=0, SQ_ENABLE=0, wait counter=0, IO_DATA high-Z.
REQ-033 RESET SHALL take priority over every handshake presented on the same edge.

Verification
REQ-034 IN_DATA=16'h4800 with core model -> OUT_DATA=16'h41A8, OUT_FLAGS=000, OUT_TIMEOUT=0, OP_COUNT 0->1; bus driven exactly 2 cycles.
REQ-035 IN_DATA=16'hBC00 -> OUT_DATA=16'hFE00, OUT_FLAGS=100; IN_DATA=16'h7C00 -> OUT_DATA=16'h7C00, OUT_FLAGS=010.
REQ-036 Core model never asserts SQ_RESULT -> OUT_VALID rises after exactly TIMEOUT_CYCLES WAIT cycles, OUT_DATA=16'hFE00, OUT_TIMEOUT=1.
REQ-037 OUT_READY held 0 for 10 cycles in DONE -> OUT_VALID, OUT_DATA stable, IN_READY=0, SQ_ENABLE=0 throughout; completes on OUT_READY=1.
REQ-038 RESET pulsed in WAIT -> next cycle IDLE, SQ_ENABLE=0, IO_DATA high-Z, OP_COUNT=0; subsequent 16'h3C00 yields 16'h3C00.
REQ-039 Bench monitor: flag any cycle where IO_DATA is driven by the host outside LOAD/START.
